// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Brief    : Opcodes, FSM state type and decode helpers for the load/store unit
//  Revision : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam logic [5:0] LB  = 6'h20;
    localparam logic [5:0] LH  = 6'h21;
    localparam logic [5:0] LWL = 6'h22;
    localparam logic [5:0] LW  = 6'h23;
    localparam logic [5:0] LBU = 6'h24;
    localparam logic [5:0] LHU = 6'h25;
    localparam logic [5:0] LWR = 6'h26;
    localparam logic [5:0] SB  = 6'h28;
    localparam logic [5:0] SH  = 6'h29;
    localparam logic [5:0] SW  = 6'h2B;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WB     = 2'd2,
        FAULT  = 2'd3
    } ls_state_t;

    function automatic logic is_load(input logic [5:0] op);
        return op inside {LB, LH, LWL, LW, LBU, LHU, LWR};
    endfunction

    function automatic logic is_store(input logic [5:0] op);
        return op inside {SB, SH, SW};
    endfunction

    // Byte accesses and the unaligned-word pair LWL/LWR can never fault.
    function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] b);
        case (op)
            LH, LHU, SH: return b[0];
            LW, SW:      return (b != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_loadstore_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_loadstore_unit_if
//  Brief    : Avalon-MM data bus between the load/store unit and memory
//  Revision : 1.0  initial release
// ============================================================================
interface mips_loadstore_unit_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface
`default_nettype wire

// File: rtl/ls_lane_align.sv
`default_nettype none
// ============================================================================
//  Module   : ls_lane_align
//  Brief    : Little-endian lane extract/merge for loads, replicate/enables for stores
//  Revision : 1.0  initial release
// ============================================================================
module ls_lane_align
    import mips_pkg::*;
(
    input  wire logic [5:0]  i_opcode,
    input  wire logic [1:0]  i_b,
    input  wire logic [31:0] i_ld_word,
    input  wire logic [31:0] i_st_src,
    output logic      [31:0] o_ld_data,
    output logic      [3:0]  o_ld_be,
    output logic      [31:0] o_st_data,
    output logic      [3:0]  o_st_be
);

    logic [31:0] w_shr;
    logic [15:0] w_half;

    assign w_shr  = i_ld_word >> {i_b, 3'b000};
    assign w_half = i_b[1] ? i_ld_word[31:16] : i_ld_word[15:0];

    always_comb begin
        o_ld_data = '0;
        o_ld_be   = '0;
        o_st_data = '0;
        o_st_be   = '0;
        case (i_opcode)
            LB:  begin o_ld_data = {{24{w_shr[7]}}, w_shr[7:0]};  o_ld_be = 4'hF; end
            LBU: begin o_ld_data = {24'h0, w_shr[7:0]};           o_ld_be = 4'hF; end
            LH:  begin o_ld_data = {{16{w_half[15]}}, w_half};    o_ld_be = 4'hF; end
            LHU: begin o_ld_data = {16'h0, w_half};               o_ld_be = 4'hF; end
            LW:  begin o_ld_data = i_ld_word;                     o_ld_be = 4'hF; end
            // 3-b as a 2-bit value is simply ~b
            LWL: begin o_ld_data = i_ld_word << {~i_b, 3'b000};   o_ld_be = 4'hF << ~i_b; end
            LWR: begin o_ld_data = w_shr;                         o_ld_be = 4'hF >> i_b; end
            SB:  begin o_st_data = {4{i_st_src[7:0]}};  o_st_be = 4'b0001 << i_b; end
            SH:  begin o_st_data = {2{i_st_src[15:0]}}; o_st_be = i_b[1] ? 4'b1100 : 4'b0011; end
            SW:  begin o_st_data = i_st_src;            o_st_be = 4'hF; end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_loadstore_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mips_loadstore_unit
//  Brief    : MIPS load/store execution over Avalon-MM with register-file writeback
//  Revision : 1.0  initial release
// ============================================================================
module mips_loadstore_unit
    import mips_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         start,
    input  wire logic [5:0]   opcode,
    input  wire logic [31:0]  base,
    input  wire logic [15:0]  offset,
    input  wire logic [31:0]  rt_data,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic              bus_error,
    output logic              write_enable_ld,
    output logic      [31:0]  write_data_ld,
    output logic      [3:0]   byteenable_ld,
    mips_loadstore_unit_if.master bus
);

    localparam logic        c_timeout_en   = (WAIT_TIMEOUT != 0);
    localparam logic [31:0] c_timeout_last = WAIT_TIMEOUT - 32'd1;

    ls_state_t   r_state, w_next;
    logic [5:0]  r_opcode;
    logic [31:0] r_ea, r_rt, r_rdata, r_wait_cnt;
    logic        r_err;

    logic [31:0] w_ea, w_ld_data, w_st_data;
    logic [3:0]  w_ld_be, w_st_be;
    logic        w_ld, w_st, w_timeout;

    assign w_ea      = base + {{16{offset[15]}}, offset};
    assign w_ld      = is_load(r_opcode);
    assign w_st      = is_store(r_opcode);
    assign w_timeout = c_timeout_en && bus.waitrequest && (r_wait_cnt == c_timeout_last);

    ls_lane_align u_align (
        .i_opcode  (r_opcode),
        .i_b       (r_ea[1:0]),
        .i_ld_word (r_rdata),
        .i_st_src  (r_rt),
        .o_ld_data (w_ld_data),
        .o_ld_be   (w_ld_be),
        .o_st_data (w_st_data),
        .o_st_be   (w_st_be)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_opcode   <= '0;
            r_ea       <= '0;
            r_rt       <= '0;
            r_rdata    <= '0;
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_opcode   <= opcode;
                r_ea       <= w_ea;
                r_rt       <= rt_data;
                r_wait_cnt <= '0;
                r_err      <= 1'b0;
            end
            if (r_state == ACCESS) begin
                if (bus.waitrequest) begin
                    r_wait_cnt <= r_wait_cnt + 32'd1;
                    r_err      <= w_timeout;
                end else if (w_ld) begin
                    r_rdata <= bus.readdata;
                end
            end
        end
    end

    always_comb begin
        w_next          = r_state;
        busy            = (r_state != IDLE);
        done            = 1'b0;
        misaligned      = 1'b0;
        bus_error       = 1'b0;
        write_enable_ld = 1'b0;
        write_data_ld   = '0;
        byteenable_ld   = '0;
        bus.address     = '0;
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.writedata   = '0;
        bus.byteenable  = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    // Unknown opcodes complete through WB with nothing to write.
                    if (!is_load(opcode) && !is_store(opcode))
                        w_next = WB;
                    else if (is_misaligned(opcode, w_ea[1:0]))
                        w_next = FAULT;
                    else
                        w_next = ACCESS;
                end
            end
            ACCESS: begin
                bus.address    = {r_ea[31:2], 2'b00};
                bus.read       = w_ld;
                bus.write      = w_st;
                bus.writedata  = w_st ? w_st_data : 32'h0;
                bus.byteenable = w_st ? w_st_be : 4'hF;
                if (!bus.waitrequest || w_timeout)
                    w_next = WB;
            end
            WB: begin
                done            = 1'b1;
                bus_error       = r_err;
                write_enable_ld = w_ld && !r_err;
                write_data_ld   = write_enable_ld ? w_ld_data : 32'h0;
                byteenable_ld   = write_enable_ld ? w_ld_be : 4'h0;
                w_next          = IDLE;
            end
            FAULT: begin
                done       = 1'b1;
                misaligned = 1'b1;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
`default_nettype wire
